// File: rtl/prog_loader.sv
// Serial program loader: assembles MSB-first words and writes them to instruction memory while holding the CPU; PROG_LOADER_PARITY_EN adds an odd-parity bit per word.
// Latency: wr_en rises one cycle after a word's last accepted bit; done pulses the cycle after the final write.
// Backpressure: ser_ready is high only in SHIFT, so the serial source stalls during WRITE, DONE and IDLE.
`timescale 1ns/1ps
module prog_loader #(
    parameter int NUM_WORDS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ser_bit,
    input  logic       ser_valid,
    output logic       ser_ready,
    output logic [3:0] WR_ADDR,
    output logic [8:0] WR_DATA,
    output logic       wr_en,
    output logic       cpu_hold,
    output logic       done,
    output logic       parity_err
);

`ifdef PROG_LOADER_PARITY_EN
    localparam int WORD_BITS = 10;
`else
    localparam int WORD_BITS = 9;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WRITE, ST_DONE} state_t;

    state_t               state, state_nxt;
    logic [3:0]           addr_cnt;
    logic [3:0]           bit_cnt;
    logic [WORD_BITS-2:0] shreg;
    logic [WORD_BITS-1:0] word_nxt;
    logic                 accept;
    logic                 last_bit;
    logic                 last_addr;
    logic                 word_ok;

    assign accept    = (state == ST_SHIFT) && ser_valid;
    assign last_bit  = (bit_cnt == 4'(WORD_BITS - 1));
    assign last_addr = (addr_cnt == 4'(NUM_WORDS - 1));
    // The word as it will look once the current bit lands in bit 0.
    assign word_nxt  = {shreg, ser_bit};

`ifdef PROG_LOADER_PARITY_EN
    assign word_ok = ^word_nxt;
`else
    assign word_ok = 1'b1;
`endif

    assign ser_ready = (state == ST_SHIFT);
    assign wr_en     = (state == ST_WRITE);
    assign done      = (state == ST_DONE);
    assign cpu_hold  = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (accept && last_bit && word_ok) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_addr ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            WR_ADDR  <= '0;
            WR_DATA  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (accept) begin
                        shreg <= word_nxt[WORD_BITS-2:0];
                        if (last_bit) begin
                            // A parity failure only clears the bit count so the same word is resent.
                            bit_cnt <= '0;
                            if (word_ok) begin
                                WR_ADDR <= addr_cnt;
                                WR_DATA <= word_nxt[WORD_BITS-1 -: 9];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    bit_cnt <= '0;
                    if (!last_addr) addr_cnt <= addr_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef PROG_LOADER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            parity_err <= 1'b0;
        end else if (accept && last_bit && !word_ok) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: a 16-word instance and a 1-word instance share the serial inputs.
`timescale 1ns/1ps
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic       ser_bit = 1'b0;
    logic       ser_valid = 1'b0;
    logic       ser_ready, ser_ready1;
    logic [3:0] wr_addr, wr_addr1;
    logic [8:0] wr_data, wr_data1;
    logic       wr_en, wr_en1;
    logic       cpu_hold, cpu_hold1;
    logic       done, done1;
    logic       parity_err, parity_err1;

    always #5 clk = ~clk;

    prog_loader #(.NUM_WORDS(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .ser_ready(ser_ready), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .wr_en(wr_en),
        .cpu_hold(cpu_hold), .done(done), .parity_err(parity_err)
    );

    prog_loader #(.NUM_WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .ser_ready(ser_ready1), .WR_ADDR(wr_addr1), .WR_DATA(wr_data1), .wr_en(wr_en1),
        .cpu_hold(cpu_hold1), .done(done1), .parity_err(parity_err1)
    );

    typedef struct {
        int dut;
        bit is_done;
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   sel = 0;
    bit   exp_perr = 1'b0;
    bit   tog = 1'b1;
    int   last_addr[2];
    int   last_data[2];
    bit   cpu_chk[2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard whenever either DUT strobes wr_en or done.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                last_addr[d] = 0;
                last_data[d] = 0;
                cpu_chk[d]   = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic       we, dn, ch;
                logic [3:0] a;
                logic [8:0] dt;
                we = (d == 1) ? wr_en1    : wr_en;
                dn = (d == 1) ? done1     : done;
                ch = (d == 1) ? cpu_hold1 : cpu_hold;
                a  = (d == 1) ? wr_addr1  : wr_addr;
                dt = (d == 1) ? wr_data1  : wr_data;
                if (cpu_chk[d]) begin
                    chk("cpu_hold_after_done", ch, 0);
                    cpu_chk[d] = 1'b0;
                end
                if (we || dn) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_event dut%0d: got wr_en=%0b done=%0b expected none", d, we, dn);
                    end else begin
                        e = q.pop_front();
                        chk("event_dut", d, e.dut);
                        chk("event_kind_done", dn, e.is_done);
                        chk("event_cycle", cyc, e.cyc);
                        if (!e.is_done) begin
                            chk("wr_addr", a, e.addr);
                            chk("wr_data", dt, e.data);
                            last_addr[d] = e.addr;
                            last_data[d] = e.data;
                        end else begin
                            cpu_chk[d] = 1'b1;
                        end
                    end
                end else begin
                    chk("wr_addr_hold", a, last_addr[d]);
                    chk("wr_data_hold", dt, last_data[d]);
                end
            end
            chk("parity_err", parity_err, exp_perr);
            chk("parity_err_1word", parity_err1, 0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        ser_valid = 1'b0;
        start = 1'b0;
        start1 = 1'b0;
        exp_perr = 1'b0;
        #1;
        chk("rst_ser_ready", ser_ready, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_queue_empty", q.size(), 0);
        q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int mode, output bit ok);
        int   guard = 0;
        bit   acc = 1'b0;
        logic rdy;
        while (!acc && guard < 200) begin
            @(negedge clk);
            #1;
            rdy = (sel == 1) ? ser_ready1 : ser_ready;
            ser_bit = b;
            case (mode)
                0:       ser_valid = 1'b1;
                1:       begin ser_valid = tog; tog = ~tog; end
                default: ser_valid = ($urandom_range(0, 3) != 0);
            endcase
            acc = ser_valid && rdy;
            guard++;
        end
        ok = acc;
        if (!acc) begin
            n_chk++;
            n_err++;
            $display("FAIL ser_ready_timeout: got no ready in 200 cycles expected ready (dut%0d)", sel);
        end
    endtask

    task automatic send_word(input int idx, input logic [8:0] w, input int mode, input bit bad,
                             input int rst_after, output bit aborted);
        bit         ok;
        int         nb;
        logic [9:0] bits;
`ifdef PROG_LOADER_PARITY_EN
        nb = 10;
        bits = {w, (~^w) ^ bad};
`else
        nb = 9;
        bits = {w, 1'b0};
`endif
        aborted = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (k == rst_after) begin
                do_reset();
                aborted = 1'b1;
                return;
            end
            send_bit(bits[9-k], mode, ok);
            if (!ok) begin
                aborted = 1'b1;
                return;
            end
        end
        if (bad) exp_perr = 1'b1;
        else     q.push_back('{sel, 1'b0, idx, int'(w), cyc + 1});
    endtask

    // mode 0: data = index, valid always; mode 1: word0 = 0x155, valid toggles; mode 2: random data and gaps.
    task automatic run_load(input int n, input int mode, input int glitch_at, input int rst_at, input int bad_at);
        bit         ab;
        logic [8:0] w;
        @(negedge clk);
        #1;
        ser_valid = 1'b0;
        if (sel == 1) start1 = 1'b1;
        else begin
            start = 1'b1;
            exp_perr = 1'b0;
        end
        @(negedge clk);
        #1;
        start = 1'b0;
        start1 = 1'b0;
        tog = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == glitch_at) begin
                @(negedge clk);
                #1 ser_valid = 1'b0;
                @(negedge clk);
                #1 start = 1'b1;
                @(negedge clk);
                #1 start = 1'b0;
            end
            if (mode == 0)                w = 9'(i);
            else if (mode == 1 && i == 0) w = 9'h155;
            else                          w = 9'($urandom_range(0, 511));
            if (i == bad_at) begin
                send_word(i, w, mode, 1'b1, -1, ab);
                if (ab) return;
            end
            send_word(i, w, mode, 1'b0, (i == rst_at) ? 5 : -1, ab);
            if (ab) return;
        end
        q.push_back('{sel, 1'b1, 0, 0, cyc + 2});
        @(negedge clk);
        #1 ser_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        #2;
        do_reset();
        sel = 0;
        run_load(16, 0, -1, -1, -1);
        sel = 1;
        run_load(1, 1, -1, -1, -1);
        run_load(1, 2, -1, -1, -1);
        sel = 0;
        run_load(16, 2, 7, -1, -1);
        run_load(16, 2, -1, 3, -1);
        run_load(16, 2, -1, -1, -1);
`ifdef PROG_LOADER_PARITY_EN
        run_load(16, 2, -1, -1, 2);
        run_load(16, 0, -1, -1, -1);
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by 1000000ns expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter NUM_WORDS, default 16, meaning instruction words written per load; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 ser_bit  input  1  serial instruction data, MSB first.
REQ-006 ser_valid  input  1  ser_bit is valid this cycle.
REQ-007 ser_ready  output  1  loader accepts ser_bit this cycle.
REQ-008 WR_ADDR  output  4  instruction-memory write address.
REQ-009 WR_DATA  output  9  instruction word to write.
REQ-010 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 cpu_hold  output  1  holds the CPU PC (drives set_pc) while loading.
REQ-012 done  output  1  one-cycle pulse when the full image is written.
REQ-013 parity_err  output  1  sticky parity-failure flag.

Function
REQ-014 States: IDLE, SHIFT, WRITE, DONE; encoding is implementation choice.
REQ-015 IDLE: ser_ready=0, wr_en=0, cpu_hold=0, done=0; start=1 -> SHIFT next cycle, address counter=0, bit counter=0.
REQ-016 start is ignored in every state except IDLE.
REQ-017 SHIFT: ser_ready=1, cpu_hold=1; a bit is accepted only on a cycle with ser_valid=1 and ser_ready=1; the shift register shifts left, ser_bit entering bit 0.
REQ-018 ser_valid=0 cycles in SHIFT stall with no state change; no timeout.
REQ-019 After the last bit of a word is accepted, the FSM moves to WRITE on the next edge.
REQ-020 WRITE lasts exactly one cycle: wr_en=1, ser_ready=0, WR_ADDR=address counter, WR_DATA=assembled word (first accepted bit in bit 8).
REQ-021 From WRITE: if address counter = NUM_WORDS-1 -> DONE; otherwise address counter increments by 1, bit counter clears, -> SHIFT.
REQ-022 Address counter never wraps within one load; maximum value is NUM_WORDS-1.
REQ-023 DONE lasts exactly one cycle: done=1, cpu_hold=1, wr_en=0; then -> IDLE, releasing cpu_hold.
REQ-024 WR_ADDR and WR_DATA hold their last values when wr_en=0.
REQ-025 Outputs are registered or decoded from registered state only; no combinational path from ser_valid/ser_bit to any output.
REQ-026 Per-word latency: last accepted bit -> wr_en high exactly 1 cycle later.

Reset
REQ-027 rst=1 forces IDLE immediately and asynchronously, regardless of state.
REQ-028 Reset values: ser_ready=0, WR_ADDR=0, WR_DATA=0, wr_en=0, cpu_hold=0, done=0, parity_err=0, address and bit counters 0.
REQ-029 Reset during SHIFT or WRITE discards the partial word; no write completes after rst is asserted.

Configuration
REQ-030 Macro PROG_LOADER_PARITY_EN selects parity checking.
REQ-031 Defined: each word is 10 serial bits, 9 data bits then one parity bit; odd parity required over all 10 bits.
REQ-032 Defined, parity fails: WRITE is skipped (wr_en stays 0), parity_err=1, address counter unchanged, bit counter clears, FSM returns to SHIFT for a resend of the same word.
REQ-033 Defined: parity_err clears only on reset or on an accepted start.
REQ-034 Not defined: words are 9 bits, no parity bit is consumed, and parity_err is tied to 0.

Verification
REQ-035 NUM_WORDS=16, start, 16 words 0x000..0x00F at ser_valid=1 continuous -> 16 wr_en pulses, WR_ADDR 0..15 carrying matching data, then done for 1 cycle, then cpu_hold=0.
REQ-036 Word 9'b101010101 with ser_valid toggled 1/0 every cycle -> single write at WR_ADDR=0 with WR_DATA=0x155, 1 cycle after the 9th accepted bit.
REQ-037 rst asserted after 5 bits of word 3 -> all outputs 0 in the same cycle; a new start then writes from address 0.
REQ-038 start pulsed while in SHIFT at address 7 -> no change; load continues to address 15.
REQ-039 PROG_LOADER_PARITY_EN defined, word 2 sent with wrong parity then correctly -> parity_err=1, one write only at WR_ADDR=2 carrying the resent data, parity_err stays 1 until the next start.
REQ-040 NUM_WORDS=1 -> exactly one write at WR_ADDR=0, then done.
